// File: rtl/instr_mem_server.sv
// -----------------------------------------------------------------------------
// instr_mem_server
//
// Responder side of the instruction-fetch interface. It owns the byte-wide
// instruction store. A load FSM fills the store from a sequential byte stream.
// Once the load completes, the store serves PC-addressed fetch words with
// one-cycle latency. While no program is resident, freeze_req tells the fetch
// stage to hold its PC.
//
// Optional feature macro: IMEM_CHECKSUM_EN
//   When defined, this adds the load_checksum output. It is the running XOR of
//   every byte accepted in the current load.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   load_start        one-cycle pulse; begins (or restarts) a program load
//   load_valid        load_byte valid this cycle
//   load_byte         program byte, sequential address order
//   load_last         marks the final byte of the load (with load_valid)
//   load_ready        store can accept a byte this cycle
//   fetch_addr        byte address (PC) from the fetch stage
//   fetch_en          fetch request this cycle
//   instruction       fetched word, big-endian byte order
//   instr_valid       instruction is valid this cycle
//   freeze_req        fetch stage must hold its PC
//   addr_err          last fetch was misaligned or out of range
//   load_overflow     sticky: a byte was offered while the store was full
//   load_checksum     (IMEM_CHECKSUM_EN only) XOR of accepted bytes
// -----------------------------------------------------------------------------
module instr_mem_server #(
  parameter int WORD_LEN      = 32,
  parameter int MEM_CELL_SIZE = 8,
  parameter int DEPTH         = 1024,
  parameter int ADDR_W        = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [MEM_CELL_SIZE-1:0] load_byte,
  input  logic                     load_last,
  output logic                     load_ready,
  input  logic [WORD_LEN-1:0]      fetch_addr,
  input  logic                     fetch_en,
  output logic [WORD_LEN-1:0]      instruction,
  output logic                     instr_valid,
  output logic                     freeze_req,
  output logic                     addr_err,
  output logic                     load_overflow
`ifdef IMEM_CHECKSUM_EN
  ,
  output logic [MEM_CELL_SIZE-1:0] load_checksum
`endif
);

  // The store is split into one bank per byte lane of a fetch word. This way
  // an aligned fetch reads every byte in a single cycle, with one registered
  // read port per bank.
  localparam int LANES  = WORD_LEN / MEM_CELL_SIZE;
  localparam int LANE_W = $clog2(LANES);
  localparam int ROWS   = DEPTH / LANES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W:0]   ptr_reg;          // 0..DEPTH inclusive; never wraps
  logic              overflow_reg;
  logic              instr_valid_reg;
  logic              addr_err_reg;
  logic              zero_reg;         // present a NOP instead of bank data
  logic [WORD_LEN-1:0] rd_word;

  logic              ptr_full;
  logic              accept;
  logic              fetch_fire;
  logic              fetch_bad;
  logic              fetch_good;
  logic [ADDR_W-1:0] fetch_a;
  logic [ADDR_W:0]   fetch_end;

  // The pointer MSB is set exactly when ptr == DEPTH (store full).
  assign ptr_full   = ptr_reg[ADDR_W];
  // A byte that coincides with load_start is dropped. The restart wins.
  assign accept     = (state_reg == ST_LOAD) && load_valid && !load_start && !ptr_full;
  assign fetch_fire = (state_reg == ST_SERVE) && fetch_en;

  assign fetch_a   = fetch_addr[ADDR_W-1:0];
  // Address of the word's last byte. Its carry bit flags a+3 >= DEPTH.
  assign fetch_end = {1'b0, fetch_a} + (ADDR_W + 1)'(LANES - 1);
  assign fetch_bad = (|fetch_a[LANE_W-1:0])
                   || (|fetch_addr[WORD_LEN-1:ADDR_W])
                   || fetch_end[ADDR_W];
  assign fetch_good = fetch_fire && !fetch_bad;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [MEM_CELL_SIZE-1:0] bank [ROWS];
      logic [MEM_CELL_SIZE-1:0] rd_reg;

      always_ff @(posedge clk) begin
        if (accept && (ptr_reg[LANE_W-1:0] == LANE_W'(gi))) begin
          bank[ptr_reg[ADDR_W-1:LANE_W]] <= load_byte;
        end
        // The read register only updates on a good fetch. Otherwise the last
        // word holds.
        if (fetch_good) begin
          rd_reg <= bank[fetch_a[ADDR_W-1:LANE_W]];
        end
      end

      // Lane 0 holds the lowest address and maps to the most significant byte.
      assign rd_word[WORD_LEN-1-gi*MEM_CELL_SIZE -: MEM_CELL_SIZE] = rd_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      ptr_reg         <= '0;
      overflow_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
      addr_err_reg    <= 1'b0;
      zero_reg        <= 1'b1;
    end else begin
      instr_valid_reg <= fetch_fire;
      if (fetch_fire) begin
        addr_err_reg <= fetch_bad;
        zero_reg     <= fetch_bad;
      end

      case (state_reg)
        ST_IDLE: begin
          if (load_start) begin
            state_reg <= ST_LOAD;
            ptr_reg   <= '0;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            ptr_reg <= '0;
          end else if (load_valid) begin
            if (ptr_full) begin
              overflow_reg <= 1'b1;
            end else begin
              ptr_reg <= ptr_reg + 1'b1;
            end
            if (load_last) begin
              state_reg <= ST_SERVE;
            end
          end
        end
        ST_SERVE: begin
          // A fetch in this same cycle is still served (see fetch_fire).
          if (load_start) begin
            state_reg <= ST_LOAD;
            ptr_reg   <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign load_ready    = (state_reg == ST_LOAD) && !ptr_full;
  assign freeze_req    = (state_reg != ST_SERVE);
  assign instr_valid   = instr_valid_reg;
  assign addr_err      = addr_err_reg;
  assign load_overflow = overflow_reg;
  assign instruction   = zero_reg ? '0 : rd_word;

`ifdef IMEM_CHECKSUM_EN
  logic [MEM_CELL_SIZE-1:0] csum_reg;

  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      csum_reg <= '0;
    end else if (accept) begin
      csum_reg <= csum_reg ^ load_byte;
    end
  end

  assign load_checksum = csum_reg;
`endif

endmodule
